// File: rtl/sine_phase_meter.sv
// Measures ch1 period and ch2-behind-ch1 lag in samples from rising mid-scale crossings with arming hysteresis.
// Outputs update on the edge sampling the closing ch1 crossing; en=0 freezes all state (no backpressure).
module sine_phase_meter #(
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 10,
    parameter int MID     = 128,
    parameter int HYST    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din1,
    input  logic [D_WIDTH-1:0] din2,
    output logic [C_WIDTH-1:0] period,
    output logic [C_WIDTH-1:0] lag,
    output logic               valid,
    output logic               locked,
    output logic               overflow
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

    localparam logic [D_WIDTH-1:0] ARM_TH  = D_WIDTH'(MID - HYST);
    localparam logic [D_WIDTH-1:0] MID_TH  = D_WIDTH'(MID);
    localparam logic [C_WIDTH-1:0] CNT_MAX = {{(C_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [C_WIDTH-1:0] ONE     = C_WIDTH'(1);

    state_t             state_q;
    logic               arm1_q, arm2_q;
    logic [C_WIDTH-1:0] cnt_q, lcnt_q, lag_hold_q;
    logic [C_WIDTH-1:0] period_q, lag_q;
    logic               valid_q, locked_q, overflow_q;

    logic               cross1, cross2, ovf_evt;
    logic               arm1_d, arm2_d;
    logic [C_WIDTH-1:0] cnt_d, lcnt_d;

    always_comb begin
        cross1  = arm1_q && (din1 >= MID_TH);
        cross2  = arm2_q && (din2 >= MID_TH);
        arm1_d  = cross1 ? 1'b0 : ((din1 < ARM_TH) ? 1'b1 : arm1_q);
        arm2_d  = cross2 ? 1'b0 : ((din2 < ARM_TH) ? 1'b1 : arm2_q);
        // Counters saturate so an unlocked (IDLE) channel never wraps into a bogus small value.
        cnt_d   = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + ONE;
        lcnt_d  = (lcnt_q == CNT_MAX) ? lcnt_q : lcnt_q + ONE;
        ovf_evt = (state_q != IDLE) && !cross1 && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            arm1_q     <= 1'b0;
            arm2_q     <= 1'b0;
            cnt_q      <= '0;
            lcnt_q     <= '0;
            lag_hold_q <= '1;
            period_q   <= '0;
            lag_q      <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (en) begin
                arm1_q <= arm1_d;
                arm2_q <= arm2_d;
                cnt_q  <= cross1 ? '0 : cnt_d;
                lcnt_q <= cross1 ? '0 : lcnt_d;
                // A ch2 crossing coincident with ch1 opens the new period with zero lag.
                if (cross1)
                    lag_hold_q <= cross2 ? '0 : '1;
                else if (cross2)
                    lag_hold_q <= lcnt_d;
                case (state_q)
                    IDLE: if (cross1) state_q <= SYNC;
                    SYNC, LOCK: begin
                        if (cross1) begin
                            state_q  <= LOCK;
                            period_q <= cnt_q + ONE;
                            lag_q    <= lag_hold_q;
                            valid_q  <= 1'b1;
                            locked_q <= 1'b1;
                        end else if (ovf_evt) begin
                            state_q    <= IDLE;
                            overflow_q <= 1'b1;
                            locked_q   <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period   = period_q;
    assign lag      = lag_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sine_phase_meter.sv
// Directed bench for sine_phase_meter: sine streams built from a 256-phase table, expectations derived by hand.
module tb_sine_phase_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] din1, din2;
    logic [9:0] period, lag;
    logic       valid, locked, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int nval    = 0;
    int vcyc    = 0;
    int prev_vcyc = 0;
    int vper    = 0;
    int vlag    = 0;
    int ph1     = 0;
    int base;

    sine_phase_meter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din1     (din1),
        .din2     (din2),
        .period   (period),
        .lag      (lag),
        .valid    (valid),
        .locked   (locked),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] sinv(input int ph);
        real r;
        r = 127.0 * $sin(6.283185307179586 * real'(ph & 255) / 256.0) + 128.5;
        return 8'($rtoi(r));
    endfunction

    task automatic tick(input logic e, input logic [7:0] a, input logic [7:0] b);
        en   = e;
        din1 = a;
        din2 = b;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            nval++;
            prev_vcyc = vcyc;
            vcyc      = cyc;
            vper      = int'(period);
            vlag      = int'(lag);
        end
    endtask

    // c2 < 0 selects a sine on ch2 lagging ch1 by lag_ph table steps, otherwise ch2 is held at c2.
    task automatic run(input int n, input int incr, input int lag_ph, input int c2, input bit gap);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, sinv(ph1), (c2 < 0) ? sinv(ph1 - lag_ph) : 8'(c2));
            ph1 += incr;
            if (gap) tick(1'b0, 8'd0, 8'd0);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; din1 = 8'd0; din2 = 8'd0;
        #12;
        check("rst_period",   int'(period),   0);
        check("rst_lag",      int'(lag),      0);
        check("rst_valid",    int'(valid),    0);
        check("rst_locked",   int'(locked),   0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b1;

        // 1: 64-sample sine, ch2 lags 16 samples
        ph1 = 0;
        run(128, 4, 64, -1, 1'b0);
        check("t1_no_early_valid", nval, 0);
        check("t1_sync_unlocked", int'(locked), 0);
        run(1, 4, 64, -1, 1'b0);
        check("t1_first_valid", int'(valid), 1);
        check("t1_period", int'(period), 64);
        check("t1_lag", int'(lag), 16);
        check("t1_locked", int'(locked), 1);
        run(128, 4, 64, -1, 1'b0);
        check("t1_valid_count", nval, 3);
        check("t1_spacing", vcyc - prev_vcyc, 64);
        check("t1_lag_repeat", vlag, 16);

        // 2: identical streams, then ch2 stuck high
        run(64, 4, 0, -1, 1'b0);
        check("t2_boundary_lag", vlag, 1);
        run(64, 4, 0, -1, 1'b0);
        check("t2_lag_zero", vlag, 0);
        check("t2_period", vper, 64);
        run(64, 4, 0, 200, 1'b0);
        check("t2_coincident_lag", vlag, 0);
        run(64, 4, 0, 200, 1'b0);
        check("t2_no_ch2_lag", vlag, 'h3FF);

        // 3: en toggling every cycle, then noise around mid-scale
        run(64, 4, 64, -1, 1'b1);
        check("t3_gap_lag", vlag, 16);
        run(64, 4, 64, -1, 1'b1);
        check("t3_gap_period", vper, 64);
        check("t3_gap_spacing", vcyc - prev_vcyc, 128);
        base = nval;
        for (int i = 0; i < 20; i++) tick(1'b1, (i % 2) ? 8'd130 : 8'd124, 8'd200);
        ph1 += 80;
        run(44, 4, 64, -1, 1'b0);
        check("t3_noise_one_valid", nval - base, 1);
        check("t3_noise_period", vper, 64);
        check("t3_noise_lag", vlag, 1);

        // 4: ch1 stuck below mid-scale until the period counter saturates
        for (int i = 0; i < 1022; i++) tick(1'b1, 8'd100, 8'd100);
        check("t4_pre_overflow", int'(overflow), 0);
        check("t4_pre_locked", int'(locked), 1);
        tick(1'b1, 8'd100, 8'd100);
        check("t4_overflow", int'(overflow), 1);
        check("t4_unlocked", int'(locked), 0);
        check("t4_period_held", int'(period), 64);
        base = nval;
        ph1  = 0;
        run(65, 4, 64, -1, 1'b0);
        check("t4_relock_valid", nval - base, 1);
        check("t4_relock_period", vper, 64);
        check("t4_relock_lag", vlag, 16);
        check("t4_relocked", int'(locked), 1);
        check("t4_overflow_sticky", int'(overflow), 1);

        // 5: asynchronous reset while locked
        #2 rst = 1'b0;
        #1;
        check("t5_period", int'(period), 0);
        check("t5_lag", int'(lag), 0);
        check("t5_locked", int'(locked), 0);
        check("t5_overflow", int'(overflow), 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'd0, 8'd0);
        #2 rst = 1'b1;
        base = nval;
        run(127, 4, 64, -1, 1'b0);
        check("t5_one_crossing_only", nval - base, 0);
        check("t5_still_unlocked", int'(locked), 0);
        run(1, 4, 64, -1, 1'b0);
        check("t5_relock_valid", int'(valid), 1);
        check("t5_relock_period", int'(period), 64);

        // 6: period change 64 -> 32 at phase 128
        run(31, 4, 64, -1, 1'b0);
        ph1 = 128;
        run(17, 8, 64, -1, 1'b0);
        check("t6_boundary_period", vper, 48);
        check("t6_boundary_lag", vlag, 16);
        run(32, 8, 64, -1, 1'b0);
        check("t6_period", vper, 32);
        check("t6_lag", vlag, 8);
        check("t6_spacing", vcyc - prev_vcyc, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_phase_meter.md
Name: sine_phase_meter

Overview:
- Receive-side counterpart of the dual-output sine generator. It consumes two sampled sine streams and measures the period of channel 1 in samples. It also measures the lag of channel 2 behind channel 1 in samples.
- It sits downstream of the generator, or of any capture path, and supplies measured period and lag to the display or check logic.
- Detection uses rising mid-scale crossings with arming hysteresis.

Parameters:
- D_WIDTH, 8, sample width; samples are unsigned and offset-binary.
- C_WIDTH, 10, width of the period and lag counters and outputs.
- MID, 128, mid-scale crossing threshold.
- HYST, 8, arming hysteresis below MID.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; one sample per cycle while high.
- din1  input  D_WIDTH  channel 1 sample (reference).
- din2  input  D_WIDTH  channel 2 sample (measured).
- period  output  C_WIDTH  last measured ch1 period in samples.
- lag  output  C_WIDTH  last measured ch2 lag in samples; all-ones means no ch2 crossing occurred in that period.
- valid  output  1  one-cycle pulse when period and lag update.
- locked  output  1  high while state is LOCK.
- overflow  output  1  sticky; set on period-counter saturation.

Behaviour:
- Reset, asynchronous, rst=0:
  - state=IDLE.
  - period=0, lag=0, valid=0, locked=0, overflow=0.
  - All counters are 0, both arm flags are 0, and lag_hold is all-ones.
- Reset mid-measurement discards all partial counts. After release, the block restarts from IDLE.
- en=0: all registers hold; valid=0. Nothing counts.
- All actions below occur only at a rising clk edge with en=1. Each channel is evaluated on the sample present at that edge.
- Arming, per channel: the arm flag is set when sample < MID-HYST.
- Crossing, per channel: occurs when arm=1 and sample >= MID. The crossing clears the arm flag.
- Samples between MID-HYST and MID neither arm nor cross.
- A channel cannot cross again until it re-arms.
- cnt, period counter:
  - Cleared to 0 on a ch1 crossing; otherwise incremented.
  - The measured period at a ch1 crossing is cnt+1. Example: crossings at samples 0 and 64 give period 64.
- lcnt, lag counter: cleared to 0 on a ch1 crossing; otherwise incremented.
- Ch2 crossing with no simultaneous ch1 crossing: lag_hold <= lcnt+1.
- Simultaneous ch1 and ch2 crossing: the ch2 crossing belongs to the new period. lag_hold <= 0 for the new period.
- State machine:
  - IDLE -> SYNC on the first ch1 crossing.
  - SYNC -> LOCK on the next ch1 crossing: period <= cnt+1, lag <= lag_hold, valid=1.
  - LOCK on each ch1 crossing: same update as SYNC->LOCK; valid=1; state stays LOCK.
  - At every ch1 crossing, lag_hold resets to all-ones. The exception is a simultaneous ch2 crossing, which sets lag_hold to 0.
  - Any state except IDLE -> IDLE when cnt would exceed 2^C_WIDTH-2 without a ch1 crossing. On that event: overflow <= 1 (sticky until reset), locked drops, and period and lag hold their last values.
- Latency: outputs are registered. valid, period and lag update on the edge that samples the closing ch1 crossing.
- Width rules:
  - Counters are unsigned C_WIDTH.
  - The maximum reportable period is 2^C_WIDTH-1.
  - Lag is always less than the period. A lag counter overflow is therefore impossible while LOCK.
- The first SYNC measurement is reported exactly like later ones. There are no warm-up discards.
- In IDLE, ch2 crossings update lag_hold, but the value is overwritten at the first ch1 crossing.

Test Plan:
1. Reset, then an ideal 64-sample sine on both channels with ch2 delayed 16 samples -> the first valid occurs at the second ch1 crossing with period=64, lag=16, locked=1. valid then repeats every 64 enabled cycles with the same values.
2. Identical ch1 and ch2 streams -> lag=0 each period. Then ch2 held at 200 constant -> the next valid reports lag=0x3FF.
3. Sine with period 64, with en toggled 1/0 every cycle -> period still reads 64 and valid pulses are 128 clocks apart. Additionally, noise oscillating between 124 and 130 after a crossing must not generate extra crossings.
4. Period 64 locked, then ch1 held at 100 constant -> after 1023 enabled samples overflow=1, locked=0, and period stays 64. Restoring the sine relocks with overflow still 1.
5. Assert rst low asynchronously, mid-cycle, during LOCK -> all outputs go to 0 immediately. After release, the first valid occurs only after two fresh ch1 crossings.
6. Period change from 64 to 32 samples (incr 4 -> 8 on a 256-entry table) -> the valid at the end of the boundary period reports the sample count actually spanned. Valids after that report period=32 and the lag scales accordingly.
